// File: rtl/i2s_rx_sched_pkg.sv
// i2s_rx_sched_pkg
//   Shared definitions for the I2S receive controller: default frame geometry
//   and the capture FSM state type.
package i2s_rx_sched_pkg;

  localparam int unsigned DEF_BCK_DIV    = 2;
  localparam int unsigned DEF_SLOT_BITS  = 32;
  localparam int unsigned DEF_SAMPLE_W   = 24;
  localparam int unsigned DEF_DISCARD_FR = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } cap_state_e;

endpackage

// File: rtl/i2s_rx_sched_clkgen.sv
// i2s_rx_sched_clkgen
//   Divides mck into the I2S bit clock and word clock and tracks the bit
//   position inside the stereo frame.
// Ports:
//   mck      in   master clock, all logic on posedge
//   rst_n    in   async active-low reset
//   en       in   run enable; low parks bck/lrck at 0 and clears counters
//   bck      out  registered bit clock
//   lrck     out  registered word clock, 0 = left slot, 1 = right slot
//   bit_cnt  out  bck position in frame, 0..2*SLOT_BITS-1, advances on bck fall
//   rise     out  strobe: this mck edge drives bck high
//   fall     out  strobe: this mck edge drives bck low
module i2s_rx_sched_clkgen
  import i2s_rx_sched_pkg::*;
#(
  parameter int unsigned BCK_DIV   = DEF_BCK_DIV,
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS,
  parameter int unsigned BIT_W     = $clog2(2 * SLOT_BITS)
) (
  input  logic             mck,
  input  logic             rst_n,
  input  logic             en,
  output logic             bck,
  output logic             lrck,
  output logic [BIT_W-1:0] bit_cnt,
  output logic             rise,
  output logic             fall
);

  localparam int unsigned DIV_W = $clog2(BCK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bck_q, bck_d;
  logic             lrck_q, lrck_d;
  logic             tick;

  always_comb begin
    tick      = en && (div_cnt_q == DIV_LAST);
    rise      = tick && !bck_q;
    fall      = tick && bck_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    bck_d     = bck_q;
    lrck_d    = lrck_q;
    if (!en) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      bck_d     = 1'b0;
      lrck_d    = 1'b0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) begin
        bck_d = ~bck_q;
      end
      if (fall) begin
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      end
      // Derived from the next count so lrck moves on the same edge bck falls.
      lrck_d = (bit_cnt_d >= SLOT_N);
    end
  end

  always_ff @(posedge mck or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bck_q     <= 1'b0;
      lrck_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bck_q     <= bck_d;
      lrck_q    <= lrck_d;
    end
  end

  assign bck     = bck_q;
  assign lrck    = lrck_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_rx_sched.sv
// i2s_rx_sched
//   Master-mode I2S receive controller. Generates bck/lrck for the ADC,
//   deserialises i2s_data into left/right words (standard I2S, MSB one bck
//   after the lrck edge), drops DISCARD_FR frames after enable, and hands each
//   stereo pair downstream over a valid/ready handshake with a sticky overrun.
// Build option:
//   I2S_OFFSET_BIN_EN  when defined, published words have their MSB inverted
//                      (two's complement -> offset binary).
// Ports:
//   mck           in   master clock
//   rst_n         in   async active-low reset
//   en            in   run enable; low parks clocks and idles capture
//   i2s_data      in   serial data from ADC
//   bck, lrck     out  registered bit / word clocks (lrck 0 = left)
//   sample_l/r    out  held stereo pair
//   sample_valid  out  held pair available
//   sample_ready  in   downstream accepts on valid & ready
//   overrun       out  sticky: pair published over an unaccepted one
//   overrun_clr   in   clears overrun (a simultaneous set wins)
module i2s_rx_sched
  import i2s_rx_sched_pkg::*;
#(
  parameter int unsigned BCK_DIV    = DEF_BCK_DIV,
  parameter int unsigned SLOT_BITS  = DEF_SLOT_BITS,
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned DISCARD_FR = DEF_DISCARD_FR
) (
  input  logic                mck,
  input  logic                rst_n,
  input  logic                en,
  input  logic                i2s_data,
  output logic                bck,
  output logic                lrck,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);
  localparam logic [BIT_W-1:0] SLOT_N   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] SAMP_N   = BIT_W'(SAMPLE_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [3:0]       DISC_LAST = (DISCARD_FR == 0) ? 4'd0 : 4'(DISCARD_FR - 1);

`ifdef I2S_OFFSET_BIN_EN
  localparam logic [SAMPLE_W-1:0] PUB_MASK = {1'b1, {(SAMPLE_W - 1){1'b0}}};
`else
  localparam logic [SAMPLE_W-1:0] PUB_MASK = '0;
`endif

  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] slot_bit;
  logic             rise, fall;
  logic             slot_r, cap_bit, word_done, frame_end;
  logic [SAMPLE_W-1:0] shifted;

  cap_state_e state_q, state_d;
  logic [3:0] discard_q, discard_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [SAMPLE_W-1:0] stage_l_q, stage_l_d;
  logic [SAMPLE_W-1:0] stage_r_q, stage_r_d;
  logic                pend_q, pend_d;
  logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
  logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  i2s_rx_sched_clkgen #(
    .BCK_DIV   (BCK_DIV),
    .SLOT_BITS (SLOT_BITS),
    .BIT_W     (BIT_W)
  ) u_clkgen (
    .mck     (mck),
    .rst_n   (rst_n),
    .en      (en),
    .bck     (bck),
    .lrck    (lrck),
    .bit_cnt (bit_cnt),
    .rise    (rise),
    .fall    (fall)
  );

  always_comb begin
    slot_r    = (bit_cnt >= SLOT_N);
    slot_bit  = slot_r ? (bit_cnt - SLOT_N) : bit_cnt;
    cap_bit   = rise && (slot_bit >= BIT_W'(1)) && (slot_bit <= SAMP_N);
    word_done = cap_bit && (slot_bit == SAMP_N);
    frame_end = fall && (bit_cnt == BIT_LAST);
    shifted   = {shift_q[SAMPLE_W-2:0], i2s_data};
  end

  // Capture FSM
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    case (state_q)
      ST_IDLE: begin
        discard_d = '0;
        if (en) begin
          state_d = (DISCARD_FR == 0) ? ST_RUN : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (frame_end) begin
          if (discard_q == DISC_LAST) begin
            state_d   = ST_RUN;
            discard_d = '0;
          end else begin
            discard_d = discard_q + 4'd1;
          end
        end
      end
      ST_RUN: ;
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d   = ST_IDLE;
      discard_d = '0;
    end
  end

  // Deserialiser; the right word's completion in RUN arms a publish for the next edge
  always_comb begin
    shift_d   = shift_q;
    stage_l_d = stage_l_q;
    stage_r_d = stage_r_q;
    pend_d    = 1'b0;
    if (!en) begin
      shift_d = '0;
    end else if (cap_bit) begin
      shift_d = shifted;
      if (word_done) begin
        if (!slot_r) begin
          stage_l_d = shifted;
        end else begin
          stage_r_d = shifted;
          pend_d    = (state_q == ST_RUN);
        end
      end
    end
  end

  // Output holding register and handshake; publish overrides a same-cycle accept
  always_comb begin
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    if (pend_q) begin
      valid_d    = 1'b1;
      sample_l_d = stage_l_q ^ PUB_MASK;
      sample_r_d = stage_r_q ^ PUB_MASK;
      if (valid_q && !sample_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge mck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      discard_q  <= '0;
      shift_q    <= '0;
      stage_l_q  <= '0;
      stage_r_q  <= '0;
      pend_q     <= 1'b0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      shift_q    <= shift_d;
      stage_l_q  <= stage_l_d;
      stage_r_q  <= stage_r_d;
      pend_q     <= pend_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_rx_sched.sv
// tb_i2s_rx_sched
//   Bench for i2s_rx_sched. An ADC model follows the DUT's bck/lrck, shifts
//   out per-frame stereo words in I2S format and posts the pairs that should
//   reach the output into an expectation list; a monitor compares every
//   accepted pair against that list.
module tb_i2s_rx_sched;

  localparam int unsigned BCK_DIV    = 2;
  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned DISCARD_FR = 1;
  localparam int unsigned FRAME_BCK  = 2 * SLOT_BITS;

`ifdef I2S_OFFSET_BIN_EN
  localparam logic [SAMPLE_W-1:0] OUT_MASK = 24'h800000;
`else
  localparam logic [SAMPLE_W-1:0] OUT_MASK = 24'h000000;
`endif

  logic                mck = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic                i2s_data;
  logic                bck, lrck;
  logic [SAMPLE_W-1:0] sample_l, sample_r;
  logic                sample_valid;
  logic                sample_ready = 1'b0;
  logic                overrun;
  logic                overrun_clr;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  // stimulus plan: words for upcoming frames (random when exhausted)
  logic [SAMPLE_W-1:0] plan_l [0:63];
  logic [SAMPLE_W-1:0] plan_r [0:63];
  int unsigned plan_wr = 0, plan_rd = 0;

  // expected pairs, written by the ADC model, consumed by the monitor
  logic [SAMPLE_W-1:0] exp_l [0:1023];
  logic [SAMPLE_W-1:0] exp_r [0:1023];
  int unsigned exp_cyc [0:1023];
  int unsigned wr = 0, rd = 0;
  bit exp_overrun = 1'b0;
  logic [SAMPLE_W-1:0] last_l = '0, last_r = '0;

  int unsigned clr_req = 0, clr_done = 0, pub_clr_req = 0, pub_clr_done = 0;
  int unsigned pos = 0, frame_idx = 0;
  event ev_frame;

  i2s_rx_sched #(
    .BCK_DIV    (BCK_DIV),
    .SLOT_BITS  (SLOT_BITS),
    .SAMPLE_W   (SAMPLE_W),
    .DISCARD_FR (DISCARD_FR)
  ) dut (
    .mck          (mck),
    .rst_n        (rst_n),
    .en           (en),
    .i2s_data     (i2s_data),
    .bck          (bck),
    .lrck         (lrck),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  initial forever #5 mck = ~mck;

  initial forever begin
    @(posedge mck);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model: data changes after bck falls, MSB one bck after the lrck edge
  initial begin
    bit started;
    bit have_fall;
    logic bck_prev;
    int unsigned last_fall;
    logic [SAMPLE_W-1:0] cur_l, cur_r, word;
    int unsigned b;
    started = 0; have_fall = 0; bck_prev = 0; last_fall = 0;
    cur_l = '0; cur_r = '0;
    i2s_data = 1'b0;
    overrun_clr = 1'b0;
    forever begin
      @(posedge mck);
      #1;
      overrun_clr = 1'b0;
      if (clr_req != clr_done) begin
        overrun_clr = 1'b1;
        clr_done = clr_done + 1;
        exp_overrun = 1'b0;
      end
      if (!rst_n || !en) begin
        started = 0; have_fall = 0; bck_prev = 0; pos = 0;
        if (!rst_n) exp_overrun = 1'b0;
        else begin
          check("idle_bck", bck, 0);
          check("idle_lrck", lrck, 0);
        end
        i2s_data = 1'($urandom);
      end else begin
        if (!started) begin
          started = 1; pos = 0; frame_idx = 0;
          if (plan_rd < plan_wr) begin
            cur_l = plan_l[plan_rd]; cur_r = plan_r[plan_rd]; plan_rd = plan_rd + 1;
          end else begin
            cur_l = SAMPLE_W'($urandom); cur_r = SAMPLE_W'($urandom);
          end
        end else if (bck_prev && !bck) begin
          if (have_fall) check("bck_period", cyc - last_fall, 2 * BCK_DIV);
          have_fall = 1; last_fall = cyc;
          pos = pos + 1;
          if (pos == FRAME_BCK) begin
            pos = 0;
            frame_idx = frame_idx + 1;
            if (plan_rd < plan_wr) begin
              cur_l = plan_l[plan_rd]; cur_r = plan_r[plan_rd]; plan_rd = plan_rd + 1;
            end else begin
              cur_l = SAMPLE_W'($urandom); cur_r = SAMPLE_W'($urandom);
            end
            -> ev_frame;
          end
        end else if (!bck_prev && bck) begin
          // the DUT has just sampled the last right-slot bit: pair becomes due
          if (pos == SLOT_BITS + SAMPLE_W && frame_idx >= DISCARD_FR) begin
            if (pub_clr_req != pub_clr_done) begin
              overrun_clr = 1'b1;
              pub_clr_done = pub_clr_done + 1;
            end
            last_l = cur_l; last_r = cur_r;
            if (rd < wr) begin
              exp_l[wr-1] = cur_l; exp_r[wr-1] = cur_r; exp_cyc[wr-1] = cyc;
              exp_overrun = 1'b1;
            end else if (wr < 1024) begin
              exp_l[wr] = cur_l; exp_r[wr] = cur_r; exp_cyc[wr] = cyc;
              wr = wr + 1;
            end
          end
        end
        check("lrck_slot", lrck, (pos >= SLOT_BITS) ? 1 : 0);
        b = pos % SLOT_BITS;
        word = (pos >= SLOT_BITS) ? cur_r : cur_l;
        if (b >= 1 && b <= SAMPLE_W) i2s_data = word[SAMPLE_W - b];
        else i2s_data = 1'($urandom);
        bck_prev = bck;
      end
    end
  end

  // Monitor: every accepted pair must match the oldest outstanding expectation
  initial begin
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge mck);
      if (rst_n) begin
        if (sample_valid && !valid_prev && rd < wr)
          check("publish_latency", cyc, exp_cyc[rd] + 1);
        if (sample_valid && sample_ready) begin
          if (rd >= wr) begin
            check("spurious_valid", 1, 0);
          end else begin
            check("pair_l", sample_l, exp_l[rd] ^ OUT_MASK);
            check("pair_r", sample_r, exp_r[rd] ^ OUT_MASK);
            rd = rd + 1;
          end
        end
        valid_prev = sample_valid;
      end else begin
        valid_prev = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge mck);
    #2;
  endtask

  task automatic frames(input int unsigned n);
    repeat (n) @(ev_frame);
  endtask

  initial begin
    int unsigned r0;
    int unsigned waited;
    logic [SAMPLE_W-1:0] held_l, held_r;

    // reset and idle
    tick(100);
    check("rst_bck", bck, 0);
    check("rst_lrck", lrck, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_l", sample_l, 0);
    check("rst_r", sample_r, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick(100);
    check("idle_valid", sample_valid, 0);
    check("idle_overrun", overrun, 0);

    // directed capture: first frame discarded, then the fixed pair every frame
    for (int i = 0; i < 4; i++) begin
      plan_l[plan_wr] = 24'hBFFFFF; plan_r[plan_wr] = 24'h3FFFFF; plan_wr = plan_wr + 1;
    end
    r0 = rd;
    sample_ready = 1'b1;
    en = 1'b1;
    frames(4);
    check("capture_pairs", rd - r0, 3);
    check("capture_l_held", sample_l, 24'hBFFFFF ^ OUT_MASK);
    check("capture_r_held", sample_r, 24'h3FFFFF ^ OUT_MASK);

    // random words with per-frame random ready and occasional clears
    for (int i = 0; i < 8; i++) begin
      frames(1);
      check("rand_overrun", overrun, exp_overrun);
      sample_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) clr_req = clr_req + 1;
    end
    frames(1);
    sample_ready = 1'b1;
    clr_req = clr_req + 1;
    frames(1);
    check("drain_overrun", overrun, 0);

    // back-pressure over two frames, then clear coinciding with a publish
    plan_l[plan_wr] = 24'h000000; plan_r[plan_wr] = 24'h5A5A5A; plan_wr = plan_wr + 1;
    plan_l[plan_wr] = 24'h7FFFFF; plan_r[plan_wr] = 24'hA5A5A5; plan_wr = plan_wr + 1;
    frames(1);
    sample_ready = 1'b0;
    frames(2);
    check("bp_overrun", overrun, 1);
    check("bp_valid", sample_valid, 1);
    check("bp_held_l", sample_l, 24'h7FFFFF ^ OUT_MASK);
    check("bp_held_r", sample_r, 24'hA5A5A5 ^ OUT_MASK);
    pub_clr_req = pub_clr_req + 1;
    frames(1);
    check("set_beats_clr", overrun, 1);
    sample_ready = 1'b1;
    clr_req = clr_req + 1;
    frames(1);
    check("overrun_cleared", overrun, 0);

    // drop en at bit_cnt 10
    frames(1);
    waited = 0;
    while (pos != 10 && waited < 200) begin
      tick(1);
      waited = waited + 1;
    end
    check("reach_bit10", pos, 10);
    held_l = sample_l; held_r = sample_r;
    en = 1'b0;
    tick(1);
    check("dis_bck", bck, 0);
    check("dis_lrck", lrck, 0);
    check("dis_held_l", sample_l, last_l ^ OUT_MASK);
    check("dis_held_r", sample_r, last_r ^ OUT_MASK);
    tick(50);
    check("dis_stable_l", sample_l, held_l);
    check("dis_stable_r", sample_r, held_r);
    check("dis_valid", sample_valid, 0);
    r0 = rd;
    en = 1'b1;
    frames(3);
    check("reenable_pairs", rd - r0, 2);

    // async reset during the right slot
    frames(1);
    waited = 0;
    while (pos < SLOT_BITS + 8 && waited < 400) begin
      tick(1);
      waited = waited + 1;
    end
    check("reach_right_slot", (pos >= SLOT_BITS + 8) ? 1 : 0, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_bck", bck, 0);
    check("arst_lrck", lrck, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_l", sample_l, 0);
    check("arst_r", sample_r, 0);
    check("arst_overrun", overrun, 0);
    tick(20);
    rst_n = 1'b1;
    r0 = rd;
    frames(3);
    check("post_reset_pairs", rd - r0, 2);
    tick(4);
    check("all_delivered", rd, wr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
